seq_det_ctrl: RTL and testbench

// Run-controller for a programmable serial bit-pattern detector. It accepts a configuration
// (pattern, length, overlap mode, target count) via valid/ready, arms the matcher and counts

---
 rtl/seq_det_ctrl_pkg.sv | 17 +
 rtl/seq_det_ctrl_if.sv | 37 +++
 rtl/seq_det_ctrl_shift_matcher.sv | 52 +++++
 rtl/seq_det_ctrl.sv | 125 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared types for the serial pattern-detector run controller: FSM states and width helpers.
// No logic of its own; imported by the interface, matcher and top.
package seq_det_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Width needed to hold a pattern length in 0..pat_w inclusive.
   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Control/CSR-side bundle of the detector: config valid/ready, gated bit stream, abort and run status.
// Pure wiring; the slave modport is the detector, the master modport is whoever configures and feeds it.
interface seq_det_ctrl_if
   import seq_det_ctrl_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) ();
   localparam int LEN_W = len_w(PAT_W);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic             in_valid;
   logic             in_bit;
   logic             abort;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;

   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      output in_valid, in_bit, abort,
      input  cfg_ready, busy, match, match_cnt, done
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      input  in_valid, in_bit, abort,
      output cfg_ready, busy, match, match_cnt, done
   );

endinterface

// File: rtl/seq_det_ctrl_shift_matcher.sv
// History shift register + fill counter with masked compare; hit is combinational in the sampling cycle.
// Shifts only when enabled, so gaps in the stream are transparent; no backpressure.
module seq_shift_matcher
   import seq_det_ctrl_pkg::*;
#(
   parameter  int PAT_W = 8,
   localparam int LEN_W = len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             data,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             overlap,
   output logic             hit
);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_nxt;

   // Compare uses the post-shift view so hit lines up with the completing bit.
   always_comb begin
      hist_nxt = {hist[PAT_W-2:0], data};
      fill_nxt = (fill < len) ? LEN_W'(fill + 1'b1) : len;
      mask     = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len));
      end
      hit = shift_en && (fill_nxt == len) &&
            ((hist_nxt & mask) == (pattern & mask));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift_en) begin
         hist <= hist_nxt;
         // Non-overlap mode demands len fresh bits before the next hit.
         fill <= (hit && !overlap) ? '0 : fill_nxt;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable serial pattern detector: config latch, FSM, match counter.
// match/done registered one cycle after the completing bit; cfg held off (cfg_ready=0) outside IDLE.
module seq_det_ctrl
   import seq_det_ctrl_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   seq_det_ctrl_if.slave bus
);
   localparam int LEN_W = len_w(PAT_W);

   state_t           state;
   state_t           state_nxt;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [CNT_W-1:0] tgt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             match_q;
   logic             done_q;

   logic             cfg_fire;
   logic             shift_en;
   logic             hit;
   logic             last_hit;
   logic [LEN_W-1:0] len_clamped;
   logic             cfg_ready;
   logic             busy;

   assign cfg_fire = (state == ST_IDLE) && bus.cfg_valid;
   // Abort wins over a same-cycle hit: suppressing the shift suppresses the hit.
   assign shift_en = (state == ST_RUN) && bus.in_valid && !bus.abort;
   assign last_hit = hit && (tgt_q != '0) && (CNT_W'(cnt_q + 1'b1) == tgt_q);

   always_comb begin
      len_clamped = bus.cfg_len;
      if (bus.cfg_len == '0) begin
         len_clamped = LEN_W'(1);
      end else if (bus.cfg_len > LEN_W'(PAT_W)) begin
         len_clamped = LEN_W'(PAT_W);
      end
   end

   seq_shift_matcher #(
      .PAT_W (PAT_W)
   ) u_matcher (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == ST_ARM),
      .shift_en (shift_en),
      .data     (bus.in_bit),
      .pattern  (pat_q),
      .len      (len_q),
      .overlap  (ovl_q),
      .hit      (hit)
   );

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            busy      = 1'b1;
            state_nxt = bus.abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (bus.abort) begin
               state_nxt = ST_IDLE;
            end else if (last_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         match_q <= hit;
         done_q  <= last_hit;
         if (cfg_fire) begin
            pat_q <= bus.cfg_pattern;
            len_q <= len_clamped;
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
            cnt_q <= '0;
         end else if (hit) begin
            cnt_q <= CNT_W'(cnt_q + 1'b1);
         end
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.busy      = busy;
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: overlap modes, target/done, abort, gaps, length clamp, async reset.
module tb_seq_det_ctrl;
   localparam int PAT_W = 8;
   localparam int CNT_W = 8;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic [7:0] tgt);
      @(negedge clk);
      bus.cfg_valid   = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_overlap = ovl;
      bus.cfg_target  = tgt;
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic v, input logic ab,
                           output logic m, output logic d);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_bit   = b;
      bus.abort    = ab;
      @(posedge clk);
      #1;
      m = bus.match;
      d = bus.done;
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
   endtask

   task automatic stop_run();
      logic m, d;
      send_bit(1'b0, 1'b0, 1'b1, m, d);
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.match !== 1'b0 ||
          bus.done !== 1'b0 || bus.match_cnt !== 8'd0) begin
         $display("FAIL reset rdy=%0b busy=%0b match=%0b done=%0b cnt=%0d expected 1 0 0 0 0",
                  bus.cfg_ready, bus.busy, bus.match, bus.done, bus.match_cnt);
         fails++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_overlap();
      logic [0:6] s = 7'b1101101;
      logic [0:6] e = 7'b0001001;
      logic m, d;
      configure(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      tests++;
      if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
         $display("FAIL ovl_busy busy=%0b rdy=%0b expected 1 0", bus.busy, bus.cfg_ready);
         fails++;
      end
      for (int i = 0; i < 7; i++) begin
         send_bit(s[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== e[i] || d !== 1'b0) begin
            $display("FAIL ovl_match bit%0d match=%0b done=%0b expected %0b 0", i + 1, m, d, e[i]);
            fails++;
         end
      end
      tests++;
      if (bus.match_cnt !== 8'd2) begin
         $display("FAIL ovl_cnt got=%0d expected 2", bus.match_cnt);
         fails++;
      end
      stop_run();
      tests++;
      if (bus.cfg_ready !== 1'b1 || bus.match_cnt !== 8'd2) begin
         $display("FAIL ovl_hold rdy=%0b cnt=%0d expected 1 2", bus.cfg_ready, bus.match_cnt);
         fails++;
      end
   endtask

   task automatic test_nonoverlap();
      logic [0:6] s = 7'b1101101;
      logic [0:6] e = 7'b0001000;
      logic m, d;
      configure(8'b0000_1101, 4'd4, 1'b0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         send_bit(s[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== e[i]) begin
            $display("FAIL novl_match bit%0d got=%0b expected %0b", i + 1, m, e[i]);
            fails++;
         end
      end
      tests++;
      if (bus.match_cnt !== 8'd1) begin
         $display("FAIL novl_cnt got=%0d expected 1", bus.match_cnt);
         fails++;
      end
      stop_run();
   endtask

   task automatic test_target();
      logic [0:6] s = 7'b1101101;
      logic [0:6] e = 7'b0001001;
      logic [0:6] f = 7'b0000001;
      logic m, d;
      configure(8'b0000_1101, 4'd4, 1'b1, 8'd2);
      for (int i = 0; i < 7; i++) begin
         send_bit(s[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== e[i] || d !== f[i]) begin
            $display("FAIL tgt_pulse bit%0d match=%0b done=%0b expected %0b %0b", i + 1, m, d, e[i], f[i]);
            fails++;
         end
      end
      tests++;
      if (bus.busy !== 1'b0 || bus.match_cnt !== 8'd2) begin
         $display("FAIL tgt_done_state busy=%0b cnt=%0d expected 0 2", bus.busy, bus.match_cnt);
         fails++;
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.cfg_ready !== 1'b1 || bus.done !== 1'b0 || bus.match !== 1'b0) begin
         $display("FAIL tgt_idle rdy=%0b done=%0b match=%0b expected 1 0 0", bus.cfg_ready, bus.done, bus.match);
         fails++;
      end
   endtask

   task automatic test_abort();
      logic [0:3] s = 4'b1101;
      logic m, d;
      configure(8'b0000_1101, 4'd4, 1'b1, 8'd1);
      for (int i = 0; i < 4; i++) begin
         send_bit(s[i], 1'b1, (i == 3), m, d);
         tests++;
         if (m !== 1'b0 || d !== 1'b0) begin
            $display("FAIL abort_pulse bit%0d match=%0b done=%0b expected 0 0", i + 1, m, d);
            fails++;
         end
      end
      tests++;
      if (bus.match_cnt !== 8'd0 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
         $display("FAIL abort_state cnt=%0d rdy=%0b busy=%0b expected 0 1 0",
                  bus.match_cnt, bus.cfg_ready, bus.busy);
         fails++;
      end
      send_bit(1'b1, 1'b1, 1'b0, m, d);
      tests++;
      if (m !== 1'b0 || d !== 1'b0 || bus.cfg_ready !== 1'b1) begin
         $display("FAIL abort_idle_ignore match=%0b done=%0b rdy=%0b expected 0 0 1", m, d, bus.cfg_ready);
         fails++;
      end
   endtask

   task automatic test_gaps();
      logic [0:3] s = 4'b1101;
      logic m, d;
      int   hits = 0;
      configure(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         send_bit(s[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== (i == 3)) begin
            $display("FAIL gap_match bit%0d got=%0b expected %0b", i + 1, m, (i == 3));
            fails++;
         end
         if (m === 1'b1) hits++;
         if (i < 3) begin
            for (int g = 0; g < 3; g++) begin
               send_bit(~s[i], 1'b0, 1'b0, m, d);
               if (m === 1'b1) hits++;
            end
         end
      end
      tests++;
      if (hits != 1 || bus.match_cnt !== 8'd1) begin
         $display("FAIL gap_count pulses=%0d cnt=%0d expected 1 1", hits, bus.match_cnt);
         fails++;
      end
      stop_run();
   endtask

   task automatic test_len_clamp();
      logic [0:4] s0 = 5'b10110;
      logic [0:8] s9 = 9'b101001011;
      logic [0:8] e9 = 9'b000000010;
      logic m, d;
      configure(8'b0000_0001, 4'd0, 1'b1, 8'd0);
      for (int i = 0; i < 5; i++) begin
         send_bit(s0[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== s0[i]) begin
            $display("FAIL len0_match bit%0d got=%0b expected %0b", i + 1, m, s0[i]);
            fails++;
         end
      end
      tests++;
      if (bus.match_cnt !== 8'd3) begin
         $display("FAIL len0_cnt got=%0d expected 3", bus.match_cnt);
         fails++;
      end
      stop_run();
      configure(8'hA5, 4'd9, 1'b1, 8'd0);
      for (int i = 0; i < 9; i++) begin
         send_bit(s9[i], 1'b1, 1'b0, m, d);
         tests++;
         if (m !== e9[i]) begin
            $display("FAIL len9_match bit%0d got=%0b expected %0b", i + 1, m, e9[i]);
            fails++;
         end
      end
      stop_run();
   endtask

   task automatic test_async_reset();
      logic [0:3] s = 4'b1101;
      logic m, d;
      configure(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         send_bit(s[i], 1'b1, 1'b0, m, d);
      end
      tests++;
      if (m !== 1'b1 || bus.match_cnt !== 8'd1) begin
         $display("FAIL arst_pre match=%0b cnt=%0d expected 1 1", m, bus.match_cnt);
         fails++;
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (bus.match !== 1'b0 || bus.match_cnt !== 8'd0 || bus.busy !== 1'b0 ||
          bus.cfg_ready !== 1'b1 || bus.done !== 1'b0) begin
         $display("FAIL arst match=%0b cnt=%0d busy=%0b rdy=%0b done=%0b expected 0 0 0 1 0",
                  bus.match, bus.match_cnt, bus.busy, bus.cfg_ready, bus.done);
         fails++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tests           = 0;
      fails           = 0;
      rst             = 1'b1;
      bus.cfg_valid   = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.cfg_target  = '0;
      bus.in_valid    = 1'b0;
      bus.in_bit      = 1'b0;
      bus.abort       = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_target();
      test_abort();
      test_gaps();
      test_len_clamp();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
